tick_period_meter: RTL and testbench
====================================

// Module: tick_period_meter
//
// PURPOSE
//   Consumer side of the clk_div tick interface. Measures the number of clk_i
//   cycles between consecutive rising edges of a tick strobe, such as a divider
//   max_tick output or any synchronous strobe. Reports each interval with a
//   1-cycle valid pulse and flags a timeout when no tick arrives within MaxVal
//   cycles. Used on-chip to check divider rates and to monitor external strobes.
//
// PARAMETERS
//   Width   26          counter and period_o width; MaxVal must fit in Width bits
//   MaxVal  50_000_000  longest measurable interval in cycles; timeout threshold (>=2)
//
// PORTS
//   clk_i      in   1      system clock, rising edge
//   rst_i      in   1      asynchronous reset, active-high
//   tick_i     in   1      tick strobe, synchronous to clk_i
//   clr_i      in   1      synchronous clear; returns the block to IDLE
//   period_o   out  Width  last measured interval in cycles (1..MaxVal)
//   valid_o    out  1      1-cycle pulse; period_o updated on the same edge
//   timeout_o  out  1      sticky: no tick for MaxVal cycles
//   min_o      out  Width  smallest period since reset/clr (TICK_METER_MINMAX_EN only)
//   max_o      out  Width  largest period since reset/clr (TICK_METER_MINMAX_EN only)
//
// BEHAVIOUR
//   - Reset (async): state=IDLE, cnt=0, tick_q=0, period_o=0, valid_o=0,
//     timeout_o=0, min_o=all-ones, max_o=0.
//   - Event definition: ev = tick_i & ~tick_q. tick_q is tick_i registered every
//     cycle, including during clr_i.
//     - A multi-cycle-high tick counts once.
//     - tick_i high in the first cycle after reset counts as an event.
//   - cnt is a Width-bit counter, cleared on every event and incremented each
//     cycle in MEASURE. It never exceeds MaxVal-1.
//   - FSM states: IDLE, MEASURE, TIMEOUT.
//     - IDLE --ev--> MEASURE: cnt<=0; valid_o is not asserted.
//     - MEASURE --ev--> MEASURE: period_o<=cnt+1, valid_o<=1, cnt<=0.
//     - MEASURE --!ev & cnt==MaxVal-1--> TIMEOUT: timeout_o<=1.
//     - TIMEOUT --ev--> MEASURE: cnt<=0, timeout_o<=0; valid_o is not asserted
//       because the interval is unknown.
//   - Boundary at cnt==MaxVal-1:
//     - An event in this cycle wins over timeout: period_o=MaxVal, valid_o=1,
//       state stays MEASURE.
//     - Consequence: with ticks exactly MaxVal apart, timeout never fires.
//   - Latency: valid_o and period_o appear 1 cycle after the event cycle.
//     valid_o is high for exactly 1 cycle.
//   - clr_i (synchronous) has priority over ev:
//     - Sets state=IDLE, cnt=0, period_o=0, valid_o=0, timeout_o=0.
//     - Resets min/max to their reset values.
//   - Reset mid-measure discards the partial interval. The first event after
//     reset only arms the block; it produces no valid_o.
//   - period_o holds its value between valid pulses. It is not changed by a timeout.
//
// CONFIGURATION
//   - Macro: TICK_METER_MINMAX_EN
//   - Defined:
//     - min_o and max_o ports exist.
//     - On each valid_o: min_o<=min(min_o, period), max_o<=max(max_o, period).
//       They update on the same edge as period_o.
//     - Reset/clr_i values: min_o=all-ones, max_o=0.
//   - Undefined: the min_o/max_o ports and their registers are absent. All other
//     behaviour is identical.
//
// TESTING
//   1. MaxVal=16, 1-cycle pulses every 5 clk -> no valid on the 1st pulse; from
//      the 2nd pulse on, valid_o 1 cycle after each pulse with period_o=5.
//   2. tick_i high for 3 cycles, next rise 10 cycles after the 1st rise -> one
//      event per rise; period_o=10.
//   3. MaxVal=16, one pulse at cycle E, then silence -> timeout_o=1 from E+17,
//      no valid. Pulse at E+30 clears timeout_o with no valid. Pulse at E+37
//      -> period_o=7.
//   4. MaxVal=16, pulses exactly 16 apart -> period_o=16 every interval;
//      timeout_o stays 0.
//   5. clr_i asserted in the same cycle as a tick -> IDLE, no valid_o,
//      period_o=0. Next two pulses 4 apart -> period_o=4. Separately, rst_i
//      mid-interval -> all outputs 0 immediately, without waiting for a clock.
//   6. TICK_METER_MINMAX_EN defined, periods 8, 3, 12 -> min_o=3, max_o=12;
//      after clr_i -> min_o=all-ones, max_o=0.

Source files
------------

// File: rtl/tick_period_meter.sv
// tick_period_meter: measures clk_i cycles between rising edges of tick_i.
// Each completed interval is reported on period_o with a 1-cycle valid_o pulse.
// timeout_o is sticky and flags MaxVal cycles without a tick.
// Optional feature macro: TICK_METER_MINMAX_EN adds min_o/max_o period tracking.
module tick_period_meter #(
  parameter int unsigned Width  = 26,
  parameter int unsigned MaxVal = 50_000_000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             tick_i,
  input  logic             clr_i,
  output logic [Width-1:0] period_o,
  output logic             valid_o,
`ifdef TICK_METER_MINMAX_EN
  output logic [Width-1:0] min_o,
  output logic [Width-1:0] max_o,
`endif
  output logic             timeout_o
);

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    TIMEOUT
  } state_e;

  localparam logic [Width-1:0] CntLast = Width'(MaxVal - 1);

  state_e           state_q, state_d;
  logic [Width-1:0] cnt_q, cnt_d;
  logic [Width-1:0] period_d;
  logic             valid_d;
  logic             timeout_d;
  logic             tick_q;
  logic             ev;
  logic [Width-1:0] meas;
`ifdef TICK_METER_MINMAX_EN
  logic [Width-1:0] min_d, max_d;
`endif

  assign ev   = tick_i & ~tick_q;
  assign meas = cnt_q + Width'(1);

  // Tick edge detector history; keeps tracking tick_i through clr_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) tick_q <= 1'b0;
    else       tick_q <= tick_i;
  end

  // State and measurement registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      period_o  <= '0;
      valid_o   <= 1'b0;
      timeout_o <= 1'b0;
`ifdef TICK_METER_MINMAX_EN
      min_o     <= '1;
      max_o     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      period_o  <= period_d;
      valid_o   <= valid_d;
      timeout_o <= timeout_d;
`ifdef TICK_METER_MINMAX_EN
      min_o     <= min_d;
      max_o     <= max_d;
`endif
    end
  end

  // Next-state and output logic; clear beats events, an event beats timeout.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_o;
    valid_d   = 1'b0;
    timeout_d = timeout_o;
`ifdef TICK_METER_MINMAX_EN
    min_d     = min_o;
    max_d     = max_o;
`endif
    if (clr_i) begin
      state_d   = IDLE;
      cnt_d     = '0;
      period_d  = '0;
      timeout_d = 1'b0;
`ifdef TICK_METER_MINMAX_EN
      min_d     = '1;
      max_d     = '0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ev) begin
            state_d = MEASURE;
            cnt_d   = '0;
          end
        end
        MEASURE: begin
          if (ev) begin
            period_d = meas;
            valid_d  = 1'b1;
            cnt_d    = '0;
`ifdef TICK_METER_MINMAX_EN
            if (meas < min_o) min_d = meas;
            if (meas > max_o) max_d = meas;
`endif
          end else if (cnt_q == CntLast) begin
            state_d   = TIMEOUT;
            timeout_d = 1'b1;
            cnt_d     = '0;
          end else begin
            cnt_d = meas;
          end
        end
        TIMEOUT: begin
          if (ev) begin
            state_d   = MEASURE;
            cnt_d     = '0;
            timeout_d = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_period_meter.sv
// Testbench for tick_period_meter: directed scenarios plus randomized tick
// trains, compared every cycle against a timestamp-based reference model.
// Honors TICK_METER_MINMAX_EN when compiled with it.
module tb_tick_period_meter;

  localparam int unsigned W    = 8;
  localparam int unsigned MAXV = 16;

  logic         clk_i  = 1'b0;
  logic         rst_i  = 1'b1;
  logic         tick_i = 1'b0;
  logic         clr_i  = 1'b0;
  logic [W-1:0] period_o;
  logic         valid_o;
  logic         timeout_o;
`ifdef TICK_METER_MINMAX_EN
  logic [W-1:0] min_o;
  logic [W-1:0] max_o;
`endif

  tick_period_meter #(
    .Width (W),
    .MaxVal(MAXV)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .tick_i   (tick_i),
    .clr_i    (clr_i),
    .period_o (period_o),
    .valid_o  (valid_o),
`ifdef TICK_METER_MINMAX_EN
    .min_o    (min_o),
    .max_o    (max_o),
`endif
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: remembers the cycle number of the last event.
  int unsigned now_c;
  int unsigned last_c;
  logic        m_prev;
  logic        m_armed;
  logic        m_to;
  logic        m_valid;
  int unsigned m_period;
  int unsigned m_min;
  int unsigned m_max;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_prev   = 1'b0;
    m_armed  = 1'b0;
    m_to     = 1'b0;
    m_valid  = 1'b0;
    m_period = 0;
    m_min    = (1 << W) - 1;
    m_max    = 0;
  endtask

  task automatic check_outputs();
    check("valid", 32'(valid_o), 32'(m_valid));
    check("period", 32'(period_o), m_period);
    check("timeout", 32'(timeout_o), 32'(m_to));
`ifdef TICK_METER_MINMAX_EN
    check("min", 32'(min_o), m_min);
    check("max", 32'(max_o), m_max);
`endif
  endtask

  // Apply one clock cycle of stimulus, advance the model, then compare.
  task automatic step(input logic t, input logic c);
    logic ev;
    tick_i = t;
    clr_i  = c;
    @(posedge clk_i);
    ev      = t & ~m_prev;
    m_prev  = t;
    m_valid = 1'b0;
    if (c) begin
      m_armed  = 1'b0;
      m_to     = 1'b0;
      m_period = 0;
      m_min    = (1 << W) - 1;
      m_max    = 0;
    end else if (ev) begin
      if (m_armed && !m_to) begin
        m_period = now_c - last_c;
        m_valid  = 1'b1;
        if (m_period < m_min) m_min = m_period;
        if (m_period > m_max) m_max = m_period;
      end
      m_armed = 1'b1;
      m_to    = 1'b0;
      last_c  = now_c;
    end else if (m_armed && !m_to && (now_c - last_c >= MAXV)) begin
      m_to = 1'b1;
    end
    now_c++;
    #1;
    check_outputs();
  endtask

  task automatic pulse_gap(input int unsigned hi, input int unsigned lo);
    for (int unsigned i = 0; i < hi; i++) step(1'b1, 1'b0);
    for (int unsigned i = 0; i < lo; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    int unsigned hi_left;
    int unsigned lo_left;
    logic t, c;
    now_c  = 0;
    last_c = 0;
    model_reset();
    #12;
    check_outputs();
    @(negedge clk_i);
    rst_i = 1'b0;

    // Tick high straight after reset counts as an event; pulses every 5.
    for (int i = 0; i < 5; i++) pulse_gap(1, 4);
    // Multi-cycle-high ticks counted once, rises 10 apart.
    for (int i = 0; i < 3; i++) pulse_gap(3, 7);
    // Timeout then recovery: pulse, 29 silent, pulse, 6 silent, pulse.
    pulse_gap(1, 29);
    check("timeout_set", 32'(timeout_o), 32'd1);
    pulse_gap(1, 6);
    check("timeout_clr", 32'(timeout_o), 32'd0);
    pulse_gap(1, 2);
    check("period_after_to", 32'(period_o), 32'd7);
    // Ticks exactly MaxVal apart never time out.
    for (int i = 0; i < 4; i++) pulse_gap(1, MAXV - 1);
    check("boundary_period", 32'(period_o), MAXV);
    check("boundary_no_to", 32'(timeout_o), 32'd0);
    // Clear coinciding with a tick, then two pulses 4 apart.
    step(1'b1, 1'b1);
    check("clr_period", 32'(period_o), 32'd0);
    step(1'b0, 1'b0);
    pulse_gap(1, 3);
    pulse_gap(1, 3);
    check("after_clr_period", 32'(period_o), 32'd4);
    // Min/max sequence 8, 3, 12 then clear.
    step(1'b1, 1'b1);
    step(1'b0, 1'b0);
    pulse_gap(1, 7);
    pulse_gap(1, 2);
    pulse_gap(1, 11);
    pulse_gap(1, 1);
    check("seq_last_period", 32'(period_o), 32'd12);
    step(1'b0, 1'b1);
    // Async reset mid-interval: outputs drop before any clock edge.
    pulse_gap(1, 4);
    pulse_gap(1, 2);
    #2;
    rst_i  = 1'b1;
    tick_i = 1'b0;
    #1;
    model_reset();
    check_outputs();
    #2;
    rst_i = 1'b0;
    pulse_gap(1, 5);
    pulse_gap(1, 5);

    // Random tick trains with occasional clears.
    hi_left = 0;
    lo_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hi_left == 0 && lo_left == 0) begin
        hi_left = $urandom_range(1, 3);
        lo_left = $urandom_range(0, 20);
      end
      if (hi_left > 0) begin
        t = 1'b1;
        hi_left--;
      end else begin
        t = 1'b0;
        lo_left--;
      end
      c = ($urandom_range(0, 63) == 0);
      step(t, c);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
